src_sel_ctrl: RTL and testbench

Sequencing controller for the board's single-bit source selector. It picks one of four single-bit sources (din[3:0]) for one output. The source changes either manually (debounced key pulse) or automatically (fixed dwell period). Disabled sources are skipped, and every switch inserts a break-before-make blanking interval so no partial or glitched data reaches the downstream LED/output stage.

---
 rtl/src_sel_ctrl.sv | 148 ++++++++++++++
 tb/tb_src_sel_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/src_sel_ctrl.sv
// Four-way single-bit source sequencer with manual/auto stepping, skipping of
// disabled sources and a break-before-make blanking interval on every switch.
module src_sel_ctrl #(
  parameter int unsigned DWELL = 50_000_000,
  parameter int unsigned BLANK = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] din,
  input  logic [3:0] src_en,
  input  logic       key_next,
  input  logic       key_mode,
  output logic       dout,
  output logic [1:0] sel,
  output logic       auto_mode,
  output logic       blanking
);

  localparam int unsigned DW = $clog2(DWELL);
  localparam int unsigned BW = $clog2(BLANK + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK - 1);
  localparam logic [DW-1:0] DWELL_ZERO = {DW{1'b0}};
  localparam logic [BW-1:0] BLANK_ZERO = {BW{1'b0}};

  typedef enum logic [0:0] {
    ST_HOLD  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  // Returns {found, index} of the first enabled source after cur, in rotation order.
  function automatic logic [2:0] find_target(input logic [1:0] cur, input logic [3:0] en);
    logic [2:0] res;
    if (en[cur + 2'd1]) begin
      res = {1'b1, cur + 2'd1};
    end else if (en[cur + 2'd2]) begin
      res = {1'b1, cur + 2'd2};
    end else if (en[cur + 2'd3]) begin
      res = {1'b1, cur + 2'd3};
    end else begin
      res = {1'b0, cur};
    end
    return res;
  endfunction

  state_t          state_r, state_s;
  logic [1:0]      sel_r, sel_s;
  logic            auto_r, auto_s;
  logic            blanking_r, blanking_s;
  logic            dout_r, dout_s;
  logic [DW-1:0]   dwell_cnt_r, dwell_cnt_s;
  logic [BW-1:0]   blank_cnt_r, blank_cnt_s;
  logic [2:0]      target_s;
  logic            cur_en_s;
  logic            expiry_s;
  logic            req_s;

  // Next-state and output decode for the HOLD/BLANK sequencer.
  always_comb begin
    state_s     = state_r;
    sel_s       = sel_r;
    auto_s      = auto_r;
    blanking_s  = blanking_r;
    dout_s      = dout_r;
    dwell_cnt_s = dwell_cnt_r;
    blank_cnt_s = blank_cnt_r;
    target_s    = find_target(sel_r, src_en);
    cur_en_s    = src_en[sel_r];
    expiry_s    = auto_r && (dwell_cnt_r == DWELL_LAST);
    req_s       = key_next || expiry_s || !cur_en_s;

    case (state_r)
      ST_HOLD: begin
        if (req_s && target_s[2]) begin
          sel_s       = target_s[1:0];
          blanking_s  = 1'b1;
          dout_s      = 1'b0;
          blank_cnt_s = BLANK_LAST;
          dwell_cnt_s = DWELL_ZERO;
          state_s     = ST_BLANK;
        end else begin
          // A disabled current source never reaches the output.
          dout_s = din[sel_r] & cur_en_s;
          if (expiry_s) begin
            dwell_cnt_s = DWELL_ZERO;
          end else if (auto_r) begin
            dwell_cnt_s = dwell_cnt_r + DW'(1'b1);
          end else begin
            dwell_cnt_s = DWELL_ZERO;
          end
        end
      end
      ST_BLANK: begin
        dwell_cnt_s = DWELL_ZERO;
        if (blank_cnt_r == BLANK_ZERO) begin
          state_s    = ST_HOLD;
          blanking_s = 1'b0;
          dout_s     = din[sel_r] & cur_en_s;
        end else begin
          blank_cnt_s = blank_cnt_r - BW'(1'b1);
          dout_s      = 1'b0;
        end
      end
      default: begin
        state_s     = ST_HOLD;
        sel_s       = 2'd0;
        blanking_s  = 1'b0;
        dout_s      = 1'b0;
        dwell_cnt_s = DWELL_ZERO;
        blank_cnt_s = BLANK_ZERO;
      end
    endcase

    if (key_mode) begin
      auto_s      = ~auto_r;
      dwell_cnt_s = DWELL_ZERO;
    end else begin
      auto_s = auto_r;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_HOLD;
      sel_r       <= 2'd0;
      auto_r      <= 1'b0;
      blanking_r  <= 1'b0;
      dout_r      <= 1'b0;
      dwell_cnt_r <= DWELL_ZERO;
      blank_cnt_r <= BLANK_ZERO;
    end else begin
      state_r     <= state_s;
      sel_r       <= sel_s;
      auto_r      <= auto_s;
      blanking_r  <= blanking_s;
      dout_r      <= dout_s;
      dwell_cnt_r <= dwell_cnt_s;
      blank_cnt_r <= blank_cnt_s;
    end
  end

  assign dout      = dout_r;
  assign sel       = sel_r;
  assign auto_mode = auto_r;
  assign blanking  = blanking_r;

endmodule

// File: tb/tb_src_sel_ctrl.sv
// Self-checking bench for src_sel_ctrl: directed vector table, multi-cycle
// corner sequences and a randomized run against a timestamp-based model.
module tb_src_sel_ctrl;

  localparam int DWELL = 8;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic [3:0] src_en;
  logic       key_next;
  logic       key_mode;
  logic       dout;
  logic [1:0] sel;
  logic       auto_mode;
  logic       blanking;

  int n_cmp = 0;
  int n_err = 0;

  src_sel_ctrl #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .din(din), .src_en(src_en),
    .key_next(key_next), .key_mode(key_mode),
    .dout(dout), .sel(sel), .auto_mode(auto_mode), .blanking(blanking)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] din;
    logic [3:0] en;
    logic       kn;
    logic       km;
    logic [1:0] sel;
    logic       dout;
    logic       blank;
    logic       autom;
  } vec_t;

  vec_t vecs[14];

  // Reference model: absolute edge timestamps instead of counters.
  bit use_model = 1'b0;
  int m_e, m_sel, m_auto, m_blank, m_dout, m_blank_end, m_dwell_start;

  task automatic model_reset();
    m_e = 0; m_sel = 0; m_auto = 0; m_blank = 0; m_dout = 0;
    m_blank_end = 0; m_dwell_start = 0;
  endtask

  task automatic model_step();
    int tgt;
    bit expiry, req;
    m_e++;
    if (!m_blank) begin
      expiry = (m_auto != 0) && (m_e - m_dwell_start == DWELL);
      req = key_next || expiry || !src_en[m_sel];
      tgt = -1;
      for (int k = 1; k <= 3; k++)
        if (tgt < 0 && src_en[(m_sel + k) % 4]) tgt = (m_sel + k) % 4;
      if (req && tgt >= 0) begin
        m_sel = tgt; m_blank = 1; m_dout = 0; m_blank_end = m_e + BLANK;
      end else begin
        m_dout = din[m_sel] & src_en[m_sel];
        if (expiry) m_dwell_start = m_e;
      end
    end else if (m_e == m_blank_end) begin
      m_blank = 0; m_dout = din[m_sel] & src_en[m_sel]; m_dwell_start = m_e;
    end else begin
      m_dout = 0;
    end
    if (key_mode) begin
      m_auto = !m_auto; m_dwell_start = m_e;
    end
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: {auto,blank,sel,dout} got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {auto_mode, blanking, sel, dout};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (use_model) model_step();
    #1;
  endtask

  task automatic drive(input logic [3:0] d, input logic [3:0] e, input logic kn, input logic km);
    din = d; src_en = e; key_next = kn; key_mode = km;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_hold", outs(), 5'b0_0_00_0);
    reset = 1'b1;
  endtask

  initial begin
    int sw[4];
    int nsw;
    logic bexp;
    sw = '{8, 18, 28, 38};

    vecs[0]  = '{4'b0101, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'b0101, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'b0101, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4'b0101, 4'b1111, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b0101, 4'b1001, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{4'b0101, 4'b1001, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{4'b1000, 4'b1001, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'b1000, 4'b1001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{4'b1000, 4'b1001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{4'b0001, 4'b1001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

    drive(4'b0101, 4'b1111, 1'b0, 1'b0);
    do_reset();

    // Directed vector table
    foreach (vecs[i]) begin
      drive(vecs[i].din, vecs[i].en, vecs[i].kn, vecs[i].km);
      tick();
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].autom, vecs[i].blank, vecs[i].sel, vecs[i].dout});
    end

    // Auto rotation: first switch at +DWELL, then every DWELL+BLANK edges
    drive(4'b0000, 4'b1111, 1'b0, 1'b1);
    tick();
    check("auto_enter", outs(), 5'b1_0_00_0);
    drive(4'b0000, 4'b1111, 1'b0, 1'b0);
    for (int j = 1; j <= 40; j++) begin
      tick();
      nsw = 0; bexp = 1'b0;
      foreach (sw[s]) begin
        if (sw[s] <= j) nsw++;
        if (sw[s] <= j && j < sw[s] + BLANK) bexp = 1'b1;
      end
      check($sformatf("auto_j%0d", j), outs(), {1'b1, bexp, 2'(nsw % 4), 1'b0});
    end
    drive(4'b0000, 4'b1111, 1'b0, 1'b1);
    tick();
    check("auto_exit", outs(), 5'b0_0_00_0);
    drive(4'b0000, 4'b1111, 1'b0, 1'b0);
    for (int j = 0; j < 20; j++) begin
      tick();
      check("manual_idle", outs(), 5'b0_0_00_0);
    end

    // Forced switch when the current source is disabled
    drive(4'b0011, 4'b1111, 1'b0, 1'b0);
    tick();
    check("pre_force", outs(), 5'b0_0_00_1);
    drive(4'b0011, 4'b1110, 1'b0, 1'b0);
    tick();
    check("force_sw", outs(), 5'b0_1_01_0);
    tick();
    check("force_blank", outs(), 5'b0_1_01_0);
    tick();
    check("force_hold", outs(), 5'b0_0_01_1);
    drive(4'b0011, 4'b0000, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("all_disabled", outs(), 5'b0_0_01_0);
    end

    // Reset asserted in the middle of BLANK
    drive(4'b0001, 4'b1111, 1'b1, 1'b0);
    tick();
    check("pre_rst_blank", outs(), 5'b0_1_10_0);
    drive(4'b0001, 4'b1111, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 check("async_reset", outs(), 5'b0_0_00_0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_reset", outs(), 5'b0_0_00_1);

    // Randomized run against the reference model
    drive(4'b0000, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();
    model_reset();
    use_model = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      din = 4'($urandom);
      key_next = ($urandom_range(0, 7) == 0);
      key_mode = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0)
        src_en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111;
      tick();
      check("random", outs(), {m_auto[0], m_blank[0], m_sel[1:0], m_dout[0]});
    end
    use_model = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
